// File: rtl/fft_pkg.sv
// Shared definitions for the iterative radix-2 FFT core: FSM states, bit reversal and
// twiddle Q-format helpers.
package fft_pkg;

  typedef enum logic [1:0] {StLoad, StCalc, StDrain} fft_state_e;

  localparam int unsigned MaxLog2N = 10;

  // Twiddles are signed Q2.(tw_w-2): 1.0 is 2**(tw_w-2).
  function automatic int unsigned tw_shift(input int unsigned tw_w);
    return tw_w - 2;
  endfunction

  function automatic int unsigned tw_one(input int unsigned tw_w);
    return 1 << (tw_w - 2);
  endfunction

  function automatic logic [MaxLog2N-1:0] bitrev(input logic [MaxLog2N-1:0] value,
                                                 input int log2n);
    logic [MaxLog2N-1:0] r;
    logic [3:0]          src;
    r = '0;
    for (int i = 0; i < MaxLog2N; i++) begin
      if (i < log2n) begin
        src  = 4'(log2n - 1 - i);
        r[i] = value[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIT butterfly with a 1/2 scale per stage.
// With FFT_INV_EN defined, i_inv selects the conjugate twiddle for the inverse transform.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int unsigned DW   = 17,
  parameter int unsigned TW_W = 16
) (
  input  logic [2*DW-1:0]   i_a,
  input  logic [2*DW-1:0]   i_b,
  input  logic [2*TW_W-1:0] i_tw,
`ifdef FFT_INV_EN
  input  logic              i_inv,
`endif
  output logic [2*DW-1:0]   o_a,
  output logic [2*DW-1:0]   o_b
);

  localparam int unsigned SH = tw_shift(TW_W);
  localparam int unsigned PW = DW + TW_W;

  logic signed [DW-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [TW_W-1:0] w_cos, w_sin;
  logic signed [PW-1:0]   w_br, w_bi, w_c, w_s, w_p_re, w_p_im;
  logic signed [DW+1:0]   w_t_re, w_t_im, w_ax_re, w_ax_im;
  logic signed [DW+1:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
  logic                   w_unused;

  assign w_a_re = i_a[2*DW-1:DW];
  assign w_a_im = i_a[DW-1:0];
  assign w_b_re = i_b[2*DW-1:DW];
  assign w_b_im = i_b[DW-1:0];
  assign w_cos  = i_tw[2*TW_W-1:TW_W];
  assign w_sin  = i_tw[TW_W-1:0];

  assign w_br = PW'(w_b_re);
  assign w_bi = PW'(w_b_im);
  assign w_c  = PW'(w_cos);
`ifdef FFT_INV_EN
  assign w_s  = i_inv ? -PW'(w_sin) : PW'(w_sin);
`else
  assign w_s  = PW'(w_sin);
`endif

  // t = b * (cos - j*sin); |t| fits PW bits for any legal operand
  assign w_p_re = w_br * w_c + w_bi * w_s;
  assign w_p_im = w_bi * w_c - w_br * w_s;
  assign w_t_re = w_p_re[PW-1:SH];
  assign w_t_im = w_p_im[PW-1:SH];

  assign w_ax_re  = (DW+2)'(w_a_re);
  assign w_ax_im  = (DW+2)'(w_a_im);
  assign w_sum_re = w_ax_re + w_t_re;
  assign w_sum_im = w_ax_im + w_t_im;
  assign w_dif_re = w_ax_re - w_t_re;
  assign w_dif_im = w_ax_im - w_t_im;

  assign o_a = {w_sum_re[DW:1], w_sum_im[DW:1]};
  assign o_b = {w_dif_re[DW:1], w_dif_im[DW:1]};

  assign w_unused = ^{w_p_re[SH-1:0], w_p_im[SH-1:0], w_sum_re[DW+1], w_sum_re[0],
                      w_sum_im[DW+1], w_sum_im[0], w_dif_re[DW+1], w_dif_re[0],
                      w_dif_im[DW+1], w_dif_im[0]};

endmodule

// File: rtl/fft_iter_core.sv
// Iterative N-point radix-2 DIT FFT: bit-reversed load, in-place stages on one shared
// butterfly, natural-order drain. Define FFT_INV_EN to add the inv port (inverse DFT).
module fft_iter_core
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned DW    = 17,
  parameter int unsigned TW_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_data,
  output logic [LOG2N-2:0]  tw_addr,
  input  logic [2*TW_W-1:0] tw_data,
`ifdef FFT_INV_EN
  input  logic              inv,
`endif
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned SW = 4;
  localparam logic [LOG2N-1:0] CntLast = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0] BfLast  = (LOG2N-1)'(N / 2 - 1);

  fft_state_e       r_state, w_state_d;
  logic [LOG2N-1:0] r_cnt, w_cnt_d;
  logic [SW-1:0]    r_stage, w_stage_d;
  logic [LOG2N-2:0] r_bf, w_bf_d;
  logic             r_ex, w_ex_d;
  logic             r_in_ready, r_out_valid, w_out_valid_d;
  logic [2*DW-1:0]  r_out_data, w_out_data_d;
  logic [2*DW-1:0]  r_mem [N];

  logic             w_in_hs, w_out_hs;
  logic [LOG2N-1:0] w_j, w_bit, w_mask, w_ia, w_ib, w_tw_full, w_wr_addr;
  logic [SW-1:0]    w_tw_sh;
  logic [2*DW-1:0]  w_bf_a, w_bf_b;
  logic             w_unused;

  // Butterfly j of stage s pairs ia (j with a 0 inserted at bit s) and ia + 2**s.
  assign w_j       = {1'b0, r_bf};
  assign w_bit     = LOG2N'(1) << r_stage;
  assign w_mask    = w_bit - LOG2N'(1);
  assign w_ia      = ((w_j & ~w_mask) << 1) | (w_j & w_mask);
  assign w_ib      = w_ia | w_bit;
  assign w_tw_sh   = SW'(LOG2N - 1) - r_stage;
  assign w_tw_full = (w_j & w_mask) << w_tw_sh;
  assign tw_addr   = w_tw_full[LOG2N-2:0];
  assign w_wr_addr = LOG2N'(bitrev(MaxLog2N'(r_cnt), LOG2N));
  assign w_unused  = w_tw_full[LOG2N-1];

  assign w_in_hs    = in_valid & r_in_ready;
  assign w_out_hs   = r_out_valid & out_ready;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state != StLoad);
  assign frame_done = w_out_hs & (r_cnt == CntLast);

`ifdef FFT_INV_EN
  logic r_inv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inv <= 1'b0;
    end else if (w_in_hs && r_cnt == '0) begin
      r_inv <= inv;
    end
  end

  fft_bfly #(.DW(DW), .TW_W(TW_W)) u_bfly (
    .i_a   (r_mem[w_ia]),
    .i_b   (r_mem[w_ib]),
    .i_tw  (tw_data),
    .i_inv (r_inv),
    .o_a   (w_bf_a),
    .o_b   (w_bf_b)
  );
`else
  fft_bfly #(.DW(DW), .TW_W(TW_W)) u_bfly (
    .i_a  (r_mem[w_ia]),
    .i_b  (r_mem[w_ib]),
    .i_tw (tw_data),
    .o_a  (w_bf_a),
    .o_b  (w_bf_b)
  );
`endif

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_stage_d     = r_stage;
    w_bf_d        = r_bf;
    w_ex_d        = r_ex;
    w_out_valid_d = r_out_valid;
    w_out_data_d  = r_out_data;
    case (r_state)
      StLoad: begin
        if (w_in_hs) begin
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == CntLast) w_state_d = StCalc;
        end
      end
      StCalc: begin
        w_ex_d = ~r_ex;
        if (r_ex) begin
          w_bf_d = r_bf + 1'b1;
          if (r_bf == BfLast) begin
            w_stage_d = r_stage + 1'b1;
            if (r_stage == SW'(LOG2N - 1)) begin
              w_stage_d = '0;
              w_state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        // First drain cycle only primes the output register.
        if (!r_out_valid) begin
          w_out_valid_d = 1'b1;
          w_out_data_d  = r_mem[r_cnt];
        end else if (out_ready) begin
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            w_out_valid_d = 1'b0;
            w_state_d     = StLoad;
          end else begin
            w_out_data_d = r_mem[w_cnt_d];
          end
        end
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StLoad;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_bf        <= '0;
      r_ex        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_stage     <= w_stage_d;
      r_bf        <= w_bf_d;
      r_ex        <= w_ex_d;
      r_in_ready  <= (w_state_d == StLoad);
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) r_mem[w_wr_addr] <= in_data;
    if (r_state == StCalc && r_ex) begin
      r_mem[w_ia] <= w_bf_a;
      r_mem[w_ib] <= w_bf_b;
    end
  end

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed bench for fft_iter_core at N=16, DW=17, TW_W=16 with a registered twiddle ROM.
module tb_fft_iter_core;

  localparam int unsigned LOG2N = 4;
  localparam int unsigned N     = 16;
  localparam int unsigned DW    = 17;
  localparam int unsigned TW_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, busy, frame_done;
  logic [2*DW-1:0]   in_data, out_data;
  logic [LOG2N-2:0]  tw_addr;
  logic [2*TW_W-1:0] tw_data;
  logic [2*TW_W-1:0] rom [N/2];

  logic [2*DW-1:0] x   [N];
  logic [2*DW-1:0] got [N];
  int n_chk = 0, n_pass = 0;
  int lat, fd_cnt, n_out;
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) tw_data <= rom[tw_addr];

  fft_iter_core #(.LOG2N(LOG2N), .DW(DW), .TW_W(TW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .tw_addr    (tw_addr),
    .tw_data    (tw_data),
`ifdef FFT_INV_EN
    .inv        (1'b0),
`endif
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic [2*DW-1:0] smp(input int re, input int im);
    logic [DW-1:0] r, i;
    r = re[DW-1:0];
    i = im[DW-1:0];
    return {r, i};
  endfunction

  function automatic logic [2*TW_W-1:0] tw(input int c, input int s);
    logic [TW_W-1:0] cc, ss;
    cc = c[TW_W-1:0];
    ss = s[TW_W-1:0];
    return {cc, ss};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic fill_x(input logic [2*DW-1:0] v);
    for (int i = 0; i < N; i++) x[i] = v;
  endtask

  // Loads x[], waits for the first output (lat = cycles after last input), then drains.
  task automatic run_frame(input bit bp, input bit gap);
    int guard, c;
    bit stalled;
    logic [2*DW-1:0] held;
    for (int i = 0; i < N; i++) begin
      if (gap && i == 5) begin
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = x[i];
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 10) check("busy_calc", busy, 1);
    end
    n_out = 0; fd_cnt = 0; c = 0; stalled = 0; held = '0;
    while (n_out < N && c < 200) begin
      out_ready = bp ? bp_pat[c % 4] : 1'b1;
      #1;
      if (stalled) check("stall_hold", out_data, held);
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        got[n_out] = out_data;
        n_out++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held    = out_data;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b0;
    #1;
    check("in_ready_after_drain", in_ready, 1);
    check("out_valid_after_drain", out_valid, 0);
    check("n_out", n_out, N);
    check("frame_done_cnt", fd_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_tw_addr"}, tw_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    rom[0] = tw(16384, 0);      rom[1] = tw(15137, 6270);
    rom[2] = tw(11585, 11585);  rom[3] = tw(6270, 15137);
    rom[4] = tw(0, 16384);      rom[5] = tw(-6270, 15137);
    rom[6] = tw(-11585, 11585); rom[7] = tw(-15137, 6270);
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // Impulse at x[0]
    fill_x('0); x[0] = smp(16384, 0);
    run_frame(1'b0, 1'b0);
    check("impulse_latency", lat, 65);
    for (int k = 0; k < N; k++) check($sformatf("impulse[%0d]", k), got[k], smp(1024, 0));

    // DC with an input gap
    fill_x(smp(1024, 0));
    run_frame(1'b0, 1'b1);
    check("dc[0]", got[0], smp(1024, 0));
    for (int k = 1; k < N; k++) check($sformatf("dc[%0d]", k), got[k], smp(0, 0));

    // Shifted impulse at x[1], drained under back-pressure
    fill_x('0); x[1] = smp(16384, 0);
    run_frame(1'b1, 1'b0);
    check("shift[0]", got[0], smp(1024, 0));
    check("shift[2]", got[2], smp(724, -725));
    check("shift[4]", got[4], smp(0, -1024));
    check("shift[8]", got[8], smp(-1024, 0));
    check("shift[10]", got[10], smp(-724, 724));
    check("shift[12]", got[12], smp(0, 1024));

    // Negative full scale
    fill_x(smp(-65536, -65536));
    run_frame(1'b0, 1'b0);
    check("negfs[0]", got[0], smp(-65536, -65536));
    for (int k = 1; k < N; k++) check($sformatf("negfs[%0d]", k), got[k], smp(0, 0));

    // Reset during CALC, then a clean impulse frame
    fill_x('0); x[0] = smp(16384, 0);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = x[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_calc_busy", busy, 1);
    check("mid_calc_tw_addr", tw_addr, 4);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_x(smp(0, 0)); x[0] = smp(16384, 0);
    run_frame(1'b0, 1'b0);
    check("post_rst_latency", lat, 65);
    for (int k = 0; k < N; k++) check($sformatf("post_rst[%0d]", k), got[k], smp(1024, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
